// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared types and constants for the instruction-memory loader.
//               Holds the loader FSM state encoding, the instruction word
//               width and the default base address / address stride.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  localparam int          INSTR_W           = 32;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd4;
  localparam logic [31:0] DEFAULT_STRIDE    = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_byte_packer
// Description : Assembles four big-endian bytes into one 32-bit instruction
//               word. Each accepted byte shifts in at the LSB end, so the
//               first byte of a word ends up in bits [31:24].
// Ports       : clk, reset     - clock / async active-high reset
//               clear          - restart byte counting for a new word
//               shift_en       - a byte is accepted this cycle
//               byte_data[7:0] - byte to shift in
//               word[31:0]     - assembled word (valid after 4 shifts)
//               last_byte      - high while the next accepted byte is the 4th
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               shift_en,
  input  logic [7:0]         byte_data,
  output logic [INSTR_W-1:0] word,
  output logic               last_byte
);

  logic [1:0] byte_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word     <= '0;
      byte_cnt <= 2'd0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
    end else if (shift_en) begin
      word     <= {word[INSTR_W-9:0], byte_data};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  assign last_byte = (byte_cnt == 2'd3);

endmodule : imem_loader_byte_packer
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Writer side of the instruction memory. Receives a program as
//               a byte stream over a valid/ready link, packs it into 32-bit
//               words and writes them at BASE_ADDR, BASE_ADDR+STRIDE, ...
//               The CPU is held (cpu_hold) for the whole load.
// Ports       : clk, reset            - clock / async active-high reset
//               start, num_words      - load request and word count
//               byte_data/valid/ready - incoming program byte stream
//               mem_we/addr/wdata     - instruction memory write port
//               busy, cpu_hold        - load in progress
//               done                  - one-cycle success pulse
//               overflow              - sticky out-of-range write error
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter logic [31:0] STRIDE      = DEFAULT_STRIDE,
  parameter int          MEM_ENTRIES = 64,
  parameter int          CNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_words,
  input  logic [7:0]         byte_data,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic               mem_we,
  output logic [31:0]        mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic               cpu_hold
);

  // Highest byte address that still lands inside the memory array.
  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_ENTRIES) - STRIDE;

  state_t               state, state_next;
  logic [31:0]          addr;
  logic [CNT_W-1:0]     word_cnt;
  logic [CNT_W-1:0]     num_words_q;
  logic [31:0]          last_addr;
  logic [INSTR_W-1:0]   last_wdata;
  logic [INSTR_W-1:0]   packed_word;
  logic                 last_byte;
  logic                 pack_clear;
  logic                 in_range;
  logic                 last_word;

  assign in_range  = (addr <= ADDR_LIMIT);
  assign last_word = ((word_cnt + CNT_W'(1)) == num_words_q);

  imem_loader_byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (pack_clear),
    .shift_en  (byte_ready & byte_valid),
    .byte_data (byte_data),
    .word      (packed_word),
    .last_byte (last_byte)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    pack_clear = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          pack_clear = 1'b1;
          state_next = (num_words == '0) ? ST_DONE : ST_RECV;
        end
      end
      ST_RECV: begin
        byte_ready = 1'b1;
        if (byte_valid && last_byte) begin
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!in_range) begin
          state_next = ST_ERR;
        end else begin
          mem_we = 1'b1;
          if (last_word) begin
            state_next = ST_DONE;
          end else begin
            pack_clear = 1'b1;
            state_next = ST_RECV;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      ST_ERR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Address/count bookkeeping. The last written address and data are kept
  // so the memory port shows stable values between write strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr        <= '0;
      word_cnt    <= '0;
      num_words_q <= '0;
      overflow    <= 1'b0;
      last_addr   <= '0;
      last_wdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            num_words_q <= num_words;
            addr        <= BASE_ADDR;
            word_cnt    <= '0;
            overflow    <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (in_range) begin
            last_addr  <= addr;
            last_wdata <= packed_word;
            word_cnt   <= word_cnt + CNT_W'(1);
            if (!last_word) begin
              addr <= addr + STRIDE;
            end
          end
        end
        ST_ERR: overflow <= 1'b1;
        default: ;
      endcase
    end
  end

  // The write cycle presents the live address/word; otherwise the held copy.
  assign mem_addr  = mem_we ? addr : last_addr;
  assign mem_wdata = mem_we ? packed_word : last_wdata;
  assign busy      = (state != ST_IDLE);
  assign cpu_hold  = busy;
  assign done      = (state == ST_DONE);

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. Byte streams are random;
//               expected writes come from a word-list model of the load.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam logic [31:0] BASE  = 32'd4;
  localparam logic [31:0] LIMIT = 32'd60;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  num_words;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        cpu_hold;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_words  (num_words),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .cpu_hold   (cpu_hold)
  );

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed write strobes and done pulses.
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  int          obs_cyc[$];
  int          done_cyc[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        obs_addr.push_back(mem_addr);
        obs_data.push_back(mem_wdata);
        obs_cyc.push_back(cyc);
      end
      if (done) done_cyc.push_back(cyc);
    end
  end

  // Stimulus bytes and model results.
  logic [7:0]  stim[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  bit          exp_done;
  bit          exp_ovf;
  int          start_cyc;
  bit          timed_out;
  logic        ovf_after_start;

  // Program image view: word i lives at BASE+4i and is bytes 4i..4i+3
  // read big-endian; the load stops at the first word beyond the array.
  task automatic build_model(input int n);
    exp_addr.delete();
    exp_data.delete();
    exp_ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = BASE + 32'(4 * i);
      if (a > LIMIT) begin
        exp_ovf = 1'b1;
        break;
      end
      exp_addr.push_back(a);
      exp_data.push_back({stim[4*i], stim[4*i+1], stim[4*i+2], stim[4*i+3]});
    end
    exp_done = !exp_ovf;
  endtask

  task automatic fill_stim(input int nbytes);
    stim.delete();
    for (int i = 0; i < nbytes; i++) stim.push_back(8'($urandom));
  endtask

  // mode 0: valid always, 1: valid every other cycle, 2: random valid.
  // poke >= 0 pulses start (num_words=7) on that cycle of the load.
  task automatic do_load(input int n, input int mode, input int poke);
    int idx = 0;
    int it = 0;
    int budget = 60 * n + 20;
    logic v;
    obs_addr.delete();
    obs_data.delete();
    obs_cyc.delete();
    done_cyc.delete();
    timed_out = 1'b0;
    @(negedge clk);
    start      = 1'b1;
    num_words  = 8'(n);
    byte_valid = 1'b0;
    start_cyc  = cyc;
    @(negedge clk);
    start = 1'b0;
    ovf_after_start = overflow;
    while (busy && it < budget) begin
      start = (it == poke);
      if (it == poke) num_words = 8'd7;
      case (mode)
        0:       v = 1'b1;
        1:       v = (it % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (idx >= stim.size()) v = 1'b0;
      byte_valid = v;
      byte_data  = v ? stim[idx] : 8'($urandom);
      if (v && byte_ready) idx++;
      it++;
      @(negedge clk);
    end
    start      = 1'b0;
    byte_valid = 1'b0;
    if (busy) timed_out = 1'b1;
  endtask

  task automatic test_reset;
    vectors++;
    if ({byte_ready, mem_we, done, overflow, busy, cpu_hold} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 000000", {byte_ready, mem_we, done, overflow, busy, cpu_hold});
    end
    vectors++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_bus: got addr %h data %h want 0", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_single;
    stim.delete();
    stim.push_back(8'h02); stim.push_back(8'h73); stim.push_back(8'h48); stim.push_back(8'h20);
    do_load(1, 0, -1);
    vectors++;
    if (obs_addr.size() != 1 || timed_out) begin
      miscompares++;
      $display("FAIL single_count: got %0d writes (timeout=%0d) want 1", obs_addr.size(), timed_out);
    end else begin
      vectors++;
      if (obs_addr[0] !== 32'd4 || obs_data[0] !== 32'h02734820) begin
        miscompares++;
        $display("FAIL single_write: got %h/%h want 00000004/02734820", obs_addr[0], obs_data[0]);
      end
      vectors++;
      if (obs_cyc[0] - start_cyc != 5) begin
        miscompares++;
        $display("FAIL single_latency: got %0d want 5", obs_cyc[0] - start_cyc);
      end
    end
    vectors++;
    if (done_cyc.size() != 1 || (done_cyc.size() == 1 && done_cyc[0] - start_cyc != 6)) begin
      miscompares++;
      $display("FAIL single_done: got %0d pulses want 1 at +6", done_cyc.size());
    end
    vectors++;
    if (mem_addr !== 32'd4 || mem_wdata !== 32'h02734820 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_hold: got %h/%h busy %b want 00000004/02734820 busy 0", mem_addr, mem_wdata, busy);
    end
  endtask

  task automatic test_toggle;
    fill_stim(12);
    do_load(3, 1, -1);
    build_model(3);
    vectors++;
    if (obs_addr.size() != exp_addr.size() || timed_out) begin
      miscompares++;
      $display("FAIL toggle_count: got %0d want %0d", obs_addr.size(), exp_addr.size());
    end else begin
      for (int i = 0; i < exp_addr.size(); i++) begin
        vectors++;
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
          miscompares++;
          $display("FAIL toggle_write%0d: got %h/%h want %h/%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
    vectors++;
    if (done_cyc.size() != 1) begin
      miscompares++;
      $display("FAIL toggle_done: got %0d pulses want 1", done_cyc.size());
    end
  endtask

  task automatic test_overflow;
    fill_stim(64);
    do_load(16, 0, -1);
    build_model(16);
    vectors++;
    if (obs_addr.size() != 15 || exp_addr.size() != 15) begin
      miscompares++;
      $display("FAIL ovf_count: got %0d writes want 15", obs_addr.size());
    end else begin
      for (int i = 0; i < 15; i++) begin
        vectors++;
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
          miscompares++;
          $display("FAIL ovf_write%0d: got %h/%h want %h/%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
    vectors++;
    if (overflow !== 1'b1 || done_cyc.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_flag: got ovf %b done %0d busy %b want 1 0 0", overflow, done_cyc.size(), busy);
    end
  endtask

  task automatic test_recovery;
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL recov_sticky: got %b want 1", overflow);
    end
    fill_stim(8);
    do_load(2, 0, -1);
    build_model(2);
    vectors++;
    if (ovf_after_start !== 1'b0) begin
      miscompares++;
      $display("FAIL recov_clear: got %b want 0", ovf_after_start);
    end
    vectors++;
    if (obs_addr.size() != 2 || obs_addr[0] !== exp_addr[0] || obs_data[1] !== exp_data[1]
        || done_cyc.size() != 1 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL recov_load: got %0d writes %0d done ovf %b want 2 1 0", obs_addr.size(), done_cyc.size(), overflow);
    end
  endtask

  task automatic test_zero_and_ignore;
    stim.delete();
    do_load(0, 0, -1);
    vectors++;
    if (obs_addr.size() != 0 || done_cyc.size() != 1 || (done_cyc.size() == 1 && done_cyc[0] - start_cyc != 1)) begin
      miscompares++;
      $display("FAIL zero_load: got %0d writes %0d done want 0 writes 1 done at +1", obs_addr.size(), done_cyc.size());
    end
    fill_stim(4);
    do_load(1, 0, 2);
    build_model(1);
    vectors++;
    if (obs_addr.size() != 1 || done_cyc.size() != 1 || timed_out) begin
      miscompares++;
      $display("FAIL busy_start: got %0d writes %0d done want 1 1", obs_addr.size(), done_cyc.size());
    end else begin
      vectors++;
      if (obs_data[0] !== exp_data[0]) begin
        miscompares++;
        $display("FAIL busy_start_data: got %h want %h", obs_data[0], exp_data[0]);
      end
    end
  endtask

  task automatic test_reset_midload;
    int idx = 0;
    fill_stim(8);
    build_model(2);
    obs_addr.delete();
    obs_data.delete();
    obs_cyc.delete();
    done_cyc.delete();
    @(negedge clk);
    start = 1'b1;
    num_words = 8'd2;
    @(negedge clk);
    start = 1'b0;
    for (int it = 0; it < 20 && idx < 6; it++) begin
      byte_valid = 1'b1;
      byte_data  = stim[idx];
      if (byte_ready) idx++;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    reset = 1'b1;
    #1;
    vectors++;
    if ({byte_ready, mem_we, done, overflow, busy, cpu_hold} !== 6'b0 || {mem_addr, mem_wdata} !== 64'h0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got ctrl %b addr %h data %h want 0",
               {byte_ready, mem_we, done, overflow, busy, cpu_hold}, mem_addr, mem_wdata);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int it = 0; it < 10; it++) begin
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      @(negedge clk);
    end
    byte_valid = 1'b0;
    vectors++;
    if (obs_addr.size() != 1 || done_cyc.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_writes: got %0d writes %0d done busy %b want 1 0 0", obs_addr.size(), done_cyc.size(), busy);
    end else begin
      vectors++;
      if (obs_data[0] !== exp_data[0]) begin
        miscompares++;
        $display("FAIL midreset_word1: got %h want %h", obs_data[0], exp_data[0]);
      end
    end
  endtask

  task automatic test_random;
    for (int r = 0; r < 5; r++) begin
      int n;
      n = $urandom_range(1, 18);
      fill_stim(4 * n);
      do_load(n, 2, -1);
      build_model(n);
      vectors++;
      if (obs_addr.size() != exp_addr.size() || timed_out) begin
        miscompares++;
        $display("FAIL rand%0d_count: got %0d want %0d (n=%0d)", r, obs_addr.size(), exp_addr.size(), n);
      end else begin
        for (int i = 0; i < exp_addr.size(); i++) begin
          vectors++;
          if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
            miscompares++;
            $display("FAIL rand%0d_write%0d: got %h/%h want %h/%h", r, i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
          end
        end
      end
      vectors++;
      if (overflow !== exp_ovf || (done_cyc.size() == 1) !== exp_done || done_cyc.size() > 1) begin
        miscompares++;
        $display("FAIL rand%0d_status: got ovf %b done %0d want ovf %b done %0d", r, overflow, done_cyc.size(), exp_ovf, exp_done);
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    num_words  = 8'd0;
    byte_data  = 8'd0;
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    reset = 1'b0;
    @(negedge clk);
    test_reset;
    test_single;
    test_toggle;
    test_overflow;
    test_recovery;
    test_zero_and_ignore;
    test_reset_midload;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_imem_loader
`default_nettype wire
